// File: rtl/vx_commit_arb.sv
`default_nettype none
// ============================================================================
//  Module   : vx_commit_arb
//  Brief    : Round-robin commit arbiter with multi-packet locking, a 2-entry
//             elastic output buffer (main + skid), and retirement counters.
//  Revision : 1.0  initial release
// ============================================================================
module vx_commit_arb #(
    parameter int NUM_REQS   = 3,
    parameter int THREAD_CNT = 4,
    parameter int NW_BITS    = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              in_valid,
    output logic [NUM_REQS-1:0]              in_ready,
    input  logic [NUM_REQS*NW_BITS-1:0]      in_wid,
    input  logic [NUM_REQS*32-1:0]           in_pc,
    input  logic [NUM_REQS*THREAD_CNT-1:0]   in_tmask,
    input  logic [NUM_REQS-1:0]              in_wb,
    input  logic [NUM_REQS*5-1:0]            in_rd,
    input  logic [NUM_REQS*THREAD_CNT*32-1:0] in_data,
    input  logic [NUM_REQS-1:0]              in_sop,
    input  logic [NUM_REQS-1:0]              in_eop,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NW_BITS-1:0]               out_wid,
    output logic [31:0]                      out_pc,
    output logic [THREAD_CNT-1:0]            out_tmask,
    output logic                             out_wb,
    output logic [4:0]                       out_rd,
    output logic [THREAD_CNT*32-1:0]         out_data,
    output logic                             out_sop,
    output logic                             out_eop,
    output logic [1:0]                       out_src,
    output logic [63:0]                      retired_cnt,
    output logic [63:0]                      retired_lanes,
    output logic                             busy
);

    localparam int c_IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    // Buffer occupancy encoding
    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    typedef struct packed {
        logic [NW_BITS-1:0]       wid;
        logic [31:0]              pc;
        logic [THREAD_CNT-1:0]    tmask;
        logic                     wb;
        logic [4:0]               rd;
        logic [THREAD_CNT*32-1:0] data;
        logic                     sop;
        logic                     eop;
        logic [1:0]               src;
    } pkt_t;

    pkt_t                 w_pkt_in [NUM_REQS];
    pkt_t                 w_sel;
    pkt_t                 r_main;
    pkt_t                 r_skid;
    logic [1:0]           r_count;
    logic [1:0]           w_count_nxt;
    logic                 r_locked;
    logic                 w_locked_nxt;
    logic [c_IDX_W-1:0]   r_lock_src;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   w_grant_idx;
    logic [c_IDX_W-1:0]   w_cand;
    logic                 w_grant_vld;
    logic                 w_can_accept;
    logic                 w_push;
    logic                 w_pop;
    logic [63:0]          w_lanes;
    logic [63:0]          r_retired_cnt;
    logic [63:0]          r_retired_lanes;
    logic                 r_busy;

    // Unpack the flat source buses into per-source packets tagged with their index
    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_unpack
            assign w_pkt_in[gi].wid   = in_wid[gi*NW_BITS +: NW_BITS];
            assign w_pkt_in[gi].pc    = in_pc[gi*32 +: 32];
            assign w_pkt_in[gi].tmask = in_tmask[gi*THREAD_CNT +: THREAD_CNT];
            assign w_pkt_in[gi].wb    = in_wb[gi];
            assign w_pkt_in[gi].rd    = in_rd[gi*5 +: 5];
            assign w_pkt_in[gi].data  = in_data[gi*THREAD_CNT*32 +: THREAD_CNT*32];
            assign w_pkt_in[gi].sop   = in_sop[gi];
            assign w_pkt_in[gi].eop   = in_eop[gi];
            assign w_pkt_in[gi].src   = 2'(gi);
        end
    endgenerate

    // Pick the granted source: the lock holder, or the first valid after the last grant
    always_comb begin
        w_grant_idx = r_rr_ptr;
        w_grant_vld = 1'b0;
        w_cand      = '0;
        if (r_locked) begin
            w_grant_idx = r_lock_src;
            w_grant_vld = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQS; k++) begin
                w_cand = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQS);
                if (!w_grant_vld && in_valid[w_cand]) begin
                    w_grant_idx = w_cand;
                    w_grant_vld = 1'b1;
                end
            end
        end
    end

    // Readiness depends only on registered occupancy; nothing is accepted in reset
    assign w_can_accept = (r_count != c_OCC_FULL) && !reset;

    // One-hot ready toward the granted source
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            in_ready[i] = w_can_accept && w_grant_vld && (w_grant_idx == c_IDX_W'(i));
        end
    end

    assign w_sel     = w_pkt_in[w_grant_idx];
    assign w_push    = |(in_valid & in_ready);
    assign out_valid = (r_count != c_OCC_EMPTY) && !reset;
    assign w_pop     = out_valid && out_ready;

    // Next occupancy and lock state from this cycle's push/pop
    always_comb begin
        w_count_nxt = r_count;
        case (r_count)
            c_OCC_EMPTY: if (w_push) w_count_nxt = c_OCC_ONE;
            c_OCC_ONE: begin
                if (w_push && !w_pop)      w_count_nxt = c_OCC_FULL;
                else if (!w_push && w_pop) w_count_nxt = c_OCC_EMPTY;
            end
            default:     if (w_pop) w_count_nxt = c_OCC_ONE;
        endcase
        w_locked_nxt = r_locked;
        if (w_push) w_locked_nxt = !w_sel.eop;
    end

    // Control state: occupancy, lock, round-robin pointer, busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= c_OCC_EMPTY;
            r_locked   <= 1'b0;
            r_lock_src <= '0;
            r_rr_ptr   <= c_IDX_W'(NUM_REQS - 1);
            r_busy     <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_locked <= w_locked_nxt;
            if (w_push) begin
                r_rr_ptr   <= w_grant_idx;
                r_lock_src <= w_grant_idx;
            end
            r_busy <= (w_count_nxt != c_OCC_EMPTY) || w_locked_nxt;
        end
    end

    // Payload storage: main feeds the output, skid catches a push while main is stalled
    always_ff @(posedge clk) begin
        case (r_count)
            c_OCC_EMPTY: if (w_push) r_main <= w_sel;
            c_OCC_ONE: begin
                if (w_push) begin
                    if (w_pop) r_main <= w_sel;
                    else       r_skid <= w_sel;
                end
            end
            default:     if (w_pop) r_main <= r_skid;
        endcase
    end

    // Active lanes of the packet at the output
    always_comb begin
        w_lanes = '0;
        for (int i = 0; i < THREAD_CNT; i++) begin
            w_lanes = w_lanes + 64'(r_main.tmask[i]);
        end
    end

    // Retirement counters advance on each delivered end-of-instruction packet
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_cnt   <= '0;
            r_retired_lanes <= '0;
        end else if (w_pop && r_main.eop) begin
            r_retired_cnt   <= r_retired_cnt + 64'd1;
            r_retired_lanes <= r_retired_lanes + w_lanes;
        end
    end

    assign out_wid       = r_main.wid;
    assign out_pc        = r_main.pc;
    assign out_tmask     = r_main.tmask;
    assign out_wb        = r_main.wb;
    assign out_rd        = r_main.rd;
    assign out_data      = r_main.data;
    assign out_sop       = r_main.sop;
    assign out_eop       = r_main.eop;
    assign out_src       = r_main.src;
    assign retired_cnt   = r_retired_cnt;
    assign retired_lanes = r_retired_lanes;
    assign busy          = r_busy;

endmodule
`default_nettype wire
